// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM state
// encoding and default latencies. The decoder and hazard unit also use them.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Multiply and divide ops occupy the low half of the encoding space.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: produces {hi,lo} for the requested
// op and flags a zero divisor so the caller can leave HI/LO untouched.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [63:0] res,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] dsor_s;
  logic [31:0] dsor_u;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        ovf;

  // Divisors are steered to 1 for x/0 and INT_MIN/-1 so the dividers never
  // see an undefined case; INT_MIN/1 already yields the required q=INT_MIN, r=0.
  always_comb begin
    ovf         = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    div_by_zero = is_div(op) && (b == 32'd0);
    dsor_s      = ((b == 32'd0) || ovf) ? 32'd1 : b;
    dsor_u      = (b == 32'd0) ? 32'd1 : b;
    prod_s      = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u      = {32'd0, a} * {32'd0, b};
    q_s         = $signed(a) / $signed(dsor_s);
    r_s         = $signed(a) % $signed(dsor_s);
    q_u         = a / dsor_u;
    r_u         = a % dsor_u;
  end

  // Select the 64-bit {hi,lo} result for the op.
  always_comb begin
    res = 64'd0;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {r_s, q_s};
      OP_DIVU:  res = {r_u, q_u};
      default:  res = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ex.sv
// EX-stage multiply/divide unit: captures a mul/div result at start, holds
// busy for a fixed latency, then commits it to the architectural HI/LO.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no op in flight; start accepted, MTHI/MTLO write directly
//   ST_BUSY | pending result held, counter running; start ignored except in
//           | the final busy cycle, where a new op is accepted back-to-back
module mdu_ex
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic [2:0]  op,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e  state;
  logic [CW-1:0] cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_dz;
  logic [63:0] res;
  logic        dz;
  logic        last;
  logic        accept;

  mdu_arith u_arith (
    .a           (A),
    .b           (B),
    .op          (op),
    .res         (res),
    .div_by_zero (dz)
  );

  // The final busy cycle counts as idle so a new op can launch on the commit edge.
  assign last   = (state == ST_BUSY) && (cnt == CW'(1));
  assign accept = start && ((state == ST_IDLE) || last);

  // Sequencer: count down the busy period, commit, then accept the next request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_dz <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (state == ST_BUSY) begin
        cnt <= cnt - CW'(1);
        if (last) begin
          if (!pend_dz) begin
            hi <= pend_hi;
            lo <= pend_lo;
          end
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      end
      if (accept) begin
        if (is_muldiv(op)) begin
          pend_hi <= res[63:32];
          pend_lo <= res[31:0];
          pend_dz <= dz;
          cnt     <= is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state   <= ST_BUSY;
          busy    <= 1'b1;
        end else if (op == OP_MTHI) begin
          hi <= A;
        end else if (op == OP_MTLO) begin
          lo <= A;
        end
      end
    end
  end

  // Read port merged with the ALU result in EX.
  assign out = (op == OP_MFHI) ? hi :
               (op == OP_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_mdu_ex.sv
// Self-checking bench for mdu_ex: directed cases plus randomized ops checked
// against an arithmetic model of HI/LO.
module tb_mdu_ex;
  import mdu_pkg::*;

  localparam int NMUL = 5;
  localparam int NDIV = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic        start;
  logic [2:0]  op;
  logic        busy;
  logic [31:0] hi, lo, out;

  int checks = 0;
  int failures = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  mdu_ex dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .start (start),
    .op    (op),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: architectural effect of a completed op on HI/LO.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] v;
    case (o)
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        v = p; hi_m = v[63:32]; lo_m = v[31:0];
      end
      OP_MULTU: begin
        p = longint'({32'd0, a}) * longint'({32'd0, b});
        v = p; hi_m = v[63:32]; lo_m = v[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b != 32'd0) begin
          sa = (o == OP_DIV) ? longint'($signed(a)) : longint'({32'd0, a});
          sb = (o == OP_DIV) ? longint'($signed(b)) : longint'({32'd0, b});
          q = sa / sb;
          r = sa % sb;
          v = q; lo_m = v[31:0];
          v = r; hi_m = v[31:0];
        end
      end
      OP_MTHI: hi_m = a;
      OP_MTLO: lo_m = a;
      default: ;
    endcase
  endtask

  // Count busy cycles from the current (busy) negedge; scramble operands and
  // optionally inject a stray MTLO to show neither disturbs the pending result.
  task automatic wait_busy(input bit inject, output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      A = $urandom;
      B = $urandom;
      if (inject && n == 3) begin
        start = 1'b1; op = OP_MTLO; A = 32'hdead_beef;
      end else begin
        start = 1'b0; op = OP_MFLO;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = OP_MFLO;
    model(o, a, b);
    wait_busy(inject, n);
    check({tag, "_cycles"}, n, is_div(o) ? NDIV : NMUL);
    check({tag, "_hi"}, hi, hi_m);
    check({tag, "_lo"}, lo, lo_m);
    op = OP_MFHI; #1 check({tag, "_mfhi"}, out, hi_m);
    op = OP_MFLO; #1 check({tag, "_mflo"}, out, lo_m);
  endtask

  task automatic do_mt(input string tag, input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = o; A = a;
    @(negedge clk);
    start = 1'b0; op = OP_MFLO;
    model(o, a, 32'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_hi"}, hi, hi_m);
    check({tag, "_lo"}, lo, lo_m);
  endtask

  initial begin
    int n;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; op = OP_MFLO; A = '0; B = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b1;

    run_op("mult_neg", OP_MULT, 32'hffff_fffe, 32'd3, 1'b0);
    check("mult_neg_hi_c", hi, 32'hffff_ffff);
    check("mult_neg_lo_c", lo, 32'hffff_fffa);

    run_op("multu_max", OP_MULTU, 32'hffff_ffff, 32'hffff_ffff, 1'b0);
    check("multu_hi_c", hi, 32'hffff_fffe);
    check("multu_lo_c", lo, 32'h0000_0001);

    run_op("div_neg", OP_DIV, 32'hffff_fff9, 32'd2, 1'b0);
    check("div_neg_lo_c", lo, 32'hffff_fffd);
    check("div_neg_hi_c", hi, 32'hffff_ffff);

    do_mt("mthi11", OP_MTHI, 32'h11);
    do_mt("mtlo22", OP_MTLO, 32'h22);
    run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 1'b0);
    check("divu_zero_hi_c", hi, 32'h11);
    check("divu_zero_lo_c", lo, 32'h22);

    do_mt("mthi", OP_MTHI, 32'h1234_5678);
    op = OP_MFHI; #1 check("mfhi_out", out, 32'h1234_5678);
    check("mfhi_busy", busy, 1'b0);
    op = OP_MULT; #1 check("out_zero", out, 32'd0);

    run_op("div_inject", OP_DIV, 32'd100, 32'd7, 1'b1);
    check("div_inject_lo_c", lo, 32'd14);

    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hffff_ffff, 1'b0);
    check("div_ovf_lo_c", lo, 32'h8000_0000);
    check("div_ovf_hi_c", hi, 32'h0000_0000);

    // MULT then DIV issued in the MULT's final busy cycle
    @(negedge clk);
    start = 1'b1; op = OP_MULT; A = 32'd1000; B = 32'hffff_fff0;
    @(negedge clk);
    start = 1'b0; op = OP_MFLO;
    model(OP_MULT, 32'd1000, 32'hffff_fff0);
    for (int i = 1; i < NMUL; i++) @(negedge clk);
    check("b2b_last_busy", busy, 1'b1);
    start = 1'b1; op = OP_DIV; A = 32'hffff_ff00; B = 32'd9;
    @(negedge clk);
    start = 1'b0; op = OP_MFLO;
    check("b2b_no_gap", busy, 1'b1);
    check("b2b_mult_hi", hi, hi_m);
    check("b2b_mult_lo", lo, lo_m);
    model(OP_DIV, 32'hffff_ff00, 32'd9);
    wait_busy(1'b0, n);
    check("b2b_div_cycles", n, NDIV);
    check("b2b_div_hi", hi, hi_m);
    check("b2b_div_lo", lo, lo_m);

    // Asynchronous reset in the third busy cycle of MULT 5x6
    @(negedge clk);
    start = 1'b1; op = OP_MULT; A = 32'd5; B = 32'd6;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    hi_m = 32'd0; lo_m = 32'd0;
    check("arst_busy", busy, 1'b0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk); reset = 1'b1;
    run_op("post_rst", OP_MULT, 32'd5, 32'd6, 1'b0);
    check("post_rst_lo_c", lo, 32'd30);
    check("post_rst_hi_c", hi, 32'd0);

    for (int k = 0; k < 30; k++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 17));
        2: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      if (is_muldiv(ro)) run_op("rand", ro, ra, rb, 1'b0);
      else               do_mt("rand_mt", ro, ra);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
